// File: rtl/stopwatch_scan_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_scan_display_pkg
//  Description : Shared types and constants for the stopwatch scan display.
//                Holds the active-low 7-segment patterns ({g,f,e,d,c,b,a}),
//                the BLANK and DASH patterns, the converter state encoding
//                and the BCD digit type.
//  Revision    : 1.0  initial release
// ============================================================================
package stopwatch_scan_display_pkg;

    typedef logic [3:0] bcd_digit_t;

    // Converter FSM state encoding
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] c_seg_blank = 7'h7F;
    localparam logic [6:0] c_seg_dash  = 7'b0111111;

    function automatic logic [6:0] seg_decode(input bcd_digit_t d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = c_seg_blank;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_scan_display_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq
//  Description : Sequential double-dabble converter, 16-bit binary to four
//                BCD digits, one bit per clock. Loads arriving while a
//                conversion is in flight are parked in a one-entry pending
//                register (newest wins) and started once the FSM is idle.
//  Ports       : clk, reset (async, active-high)
//                i_value/i_load  operand and its single-cycle strobe
//                o_busy          conversion in progress
//                o_done          one-cycle strobe with o_bcd/o_ovf valid
//                o_bcd           four BCD digits (low 16 bits)
//                o_ovf           operand was above 9999
//  Revision    : 1.0  initial release
// ============================================================================
module bin_to_bcd_seq
    import stopwatch_scan_display_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_value,
    input  logic        i_load,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_bcd,
    output logic        o_ovf
);

    logic [1:0]  r_state;
    logic [15:0] r_shift;
    logic [15:0] r_acc;
    logic [15:0] r_pend_value;
    logic        r_pend_valid;
    logic [4:0]  r_count;
    logic        r_ovf_run;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_bcd;
    logic        r_ovf;
    logic [15:0] w_acc_adj;
    logic [15:0] w_operand;

    // A fresh load in IDLE takes priority over a parked value.
    assign w_operand = i_load ? i_value : r_pend_value;

    // Add-3 correction on every nibble that would carry past 9 after shifting.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign w_acc_adj[gi*4 +: 4] = (r_acc[gi*4 +: 4] >= 4'd5) ?
                                          r_acc[gi*4 +: 4] + 4'd3 :
                                          r_acc[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_shift      <= '0;
            r_acc        <= '0;
            r_pend_value <= '0;
            r_pend_valid <= 1'b0;
            r_count      <= '0;
            r_ovf_run    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_bcd        <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (i_load || r_pend_valid) begin
                        r_shift      <= w_operand;
                        r_ovf_run    <= (w_operand > 16'd9999);
                        r_acc        <= '0;
                        r_count      <= 5'd16;
                        r_busy       <= 1'b1;
                        r_pend_valid <= 1'b0;
                        r_state      <= c_st_shift;
                    end
                end
                c_st_shift: begin
                    // Digits above the fourth fall off the top; the overflow
                    // flag covers that case.
                    r_acc   <= {w_acc_adj[14:0], r_shift[15]};
                    r_shift <= {r_shift[14:0], 1'b0};
                    r_count <= r_count - 5'd1;
                    if (r_count == 5'd1) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    r_bcd   <= r_acc;
                    r_ovf   <= r_ovf_run;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase

            // Any load outside IDLE (including the DONE cycle) is parked.
            if (i_load && (r_state != c_st_idle)) begin
                r_pend_value <= i_value;
                r_pend_valid <= 1'b1;
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_bcd  = r_bcd;
    assign o_ovf  = r_ovf;

endmodule
`default_nettype wire

// File: rtl/stopwatch_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_scan_display
//  Description : Converts a 16-bit tenths-of-second count to BCD and scans it
//                onto a common-anode 4-digit 7-segment display with leading
//                zero blanking, a fixed decimal point and an overflow pattern.
//  Ports       : clk, reset (async, active-high)
//                value/load  count to display and its single-cycle strobe
//                anodes      active-low one-hot digit enables (0 = rightmost)
//                segments    active-low {g,f,e,d,c,b,a}
//                dp          active-low decimal point
//                busy        conversion in progress
//  Revision    : 1.0  initial release
// ============================================================================
module stopwatch_scan_display
    import stopwatch_scan_display_pkg::*;
#(
    parameter int SCAN_DIV      = 100_000,
    parameter int DP_DIGIT      = 1,
    parameter int BLANK_LEADING = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    output logic [3:0]  anodes,
    output logic [6:0]  segments,
    output logic        dp,
    output logic        busy
);

    localparam int              c_cnt_w    = $clog2(SCAN_DIV);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SCAN_DIV - 1);
    localparam logic [1:0]      c_dp_idx   = 2'(DP_DIGIT);

    logic              w_done;
    logic [15:0]       w_bcd;
    logic              w_ovf;
    logic [15:0]       r_disp_bcd;
    logic              r_disp_ovf;
    logic [c_cnt_w-1:0] r_scan_cnt;
    logic [1:0]        r_digit_idx;
    logic [3:0]        r_anodes;
    logic [6:0]        r_segments;
    logic              r_dp;
    logic [3:0]        w_zero;
    logic [3:0]        w_blank;
    bcd_digit_t        w_digit;
    logic [3:0]        w_anodes_nx;
    logic [6:0]        w_seg_nx;
    logic              w_dp_nx;

    bin_to_bcd_seq u_conv (
        .clk     (clk),
        .reset   (reset),
        .i_value (value),
        .i_load  (load),
        .o_busy  (busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd),
        .o_ovf   (w_ovf)
    );

    // Display register: digits and overflow flag change together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_disp_bcd <= '0;
            r_disp_ovf <= 1'b0;
        end else if (w_done) begin
            r_disp_bcd <= w_bcd;
            r_disp_ovf <= w_ovf;
        end
    end

    // Digit slot timer and index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= 2'd0;
        end else if (r_scan_cnt == c_cnt_last) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= r_digit_idx + 2'd1;
        end else begin
            r_scan_cnt  <= r_scan_cnt + 1'b1;
        end
    end

    // A digit is blanked when it sits above the decimal point and it and
    // every digit to its left are zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_blank
            assign w_zero[gi]  = (r_disp_bcd[gi*4 +: 4] == 4'd0);
            assign w_blank[gi] = (BLANK_LEADING != 0) && (gi > DP_DIGIT) &&
                                 (&w_zero[3:gi]);
        end
    endgenerate

    always_comb begin
        w_digit     = r_disp_bcd[{r_digit_idx, 2'b00} +: 4];
        w_anodes_nx = ~(4'b0001 << r_digit_idx);
        w_seg_nx    = seg_decode(w_digit);
        w_dp_nx     = !((r_digit_idx == c_dp_idx) && !r_disp_ovf);
        if (r_disp_ovf) begin
            w_seg_nx = c_seg_dash;
        end else if (w_blank[r_digit_idx]) begin
            w_anodes_nx = 4'b1111;
            w_seg_nx    = c_seg_blank;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_anodes   <= 4'b1111;
            r_segments <= c_seg_blank;
            r_dp       <= 1'b1;
        end else begin
            r_anodes   <= w_anodes_nx;
            r_segments <= w_seg_nx;
            r_dp       <= w_dp_nx;
        end
    end

    assign anodes   = r_anodes;
    assign segments = r_segments;
    assign dp       = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_scan_display
//  Description : Directed self-checking bench for stopwatch_scan_display with
//                a short scan divider.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stopwatch_scan_display;

    localparam logic [6:0] c_s0 = 7'h40, c_s1 = 7'h79, c_s2 = 7'h24,
                           c_s3 = 7'h30, c_s4 = 7'h19, c_s7 = 7'h78,
                           c_s9 = 7'h10, c_sb = 7'h7F, c_sd = 7'h3F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic [3:0]  anodes;
    logic [6:0]  segments;
    logic        dp;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    stopwatch_scan_display #(
        .SCAN_DIV      (4),
        .DP_DIGIT      (1),
        .BLANK_LEADING (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .load     (load),
        .anodes   (anodes),
        .segments (segments),
        .dp       (dp),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Watch a full scan rotation and compare what each digit showed.
    task automatic check_display(input string tag, input logic [3:0] exp_shown,
                                 input logic [27:0] exp_seg, input logic [3:0] exp_dp);
        logic [3:0]  shown  = '0;
        logic [27:0] seg_obs = {4{7'h7F}};
        logic [3:0]  dp_obs = 4'hF;
        int          bad = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            case (anodes)
                4'b1111: if (segments != 7'h7F) bad++;
                4'b1110, 4'b1101, 4'b1011, 4'b0111: begin
                    for (int i = 0; i < 4; i++) begin
                        if (!anodes[i]) begin
                            shown[i]        = 1'b1;
                            seg_obs[i*7 +: 7] = segments;
                            dp_obs[i]       = dp;
                        end
                    end
                end
                default: bad++;
            endcase
        end
        chk({tag, "_shown"}, shown, exp_shown);
        chk({tag, "_seg"}, seg_obs, exp_seg);
        chk({tag, "_dp"}, dp_obs, exp_dp);
        chk({tag, "_onehot"}, bad, 0);
    endtask

    // Single load, then measure busy width and display-register latency.
    task automatic load_and_time(input string tag, input logic [15:0] v,
                                 input logic [15:0] exp_bcd, input logic exp_ovf);
        int busy_cyc = 0;
        int lat = -1;
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy) busy_cyc++;
            if (lat < 0 && dut.r_disp_bcd == exp_bcd && dut.r_disp_ovf == exp_ovf) lat = k;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, busy_cyc, 17);
        chk({tag, "_latency"}, lat, 18);
    endtask

    initial begin
        int t_a, t_b, saw_c;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_anodes", anodes, 4'b1111);
        chk("rst_segments", segments, 7'h7F);
        chk("rst_dp", dp, 1'b1);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;

        // 1: idle display "  0.0"
        check_display("idle", 4'b0011, {c_sb, c_sb, c_s0, c_s0}, 4'b1101);

        // 2: 1234 -> "123.4"
        load_and_time("v1234", 16'd1234, 16'h1234, 1'b0);
        check_display("v1234", 4'b1111, {c_s1, c_s2, c_s3, c_s4}, 4'b1101);

        // 3: 7 -> "  0.7"
        load_and_time("v7", 16'd7, 16'h0007, 1'b0);
        check_display("v7", 4'b0011, {c_sb, c_sb, c_s0, c_s7}, 4'b1101);

        // Largest in-range value
        load_and_time("v9999", 16'd9999, 16'h9999, 1'b0);
        check_display("v9999", 4'b1111, {c_s9, c_s9, c_s9, c_s9}, 4'b1101);

        // 4: overflow then back to zero
        load_and_time("v10000", 16'd10000, 16'h0000, 1'b1);
        check_display("v10000", 4'b1111, {c_sd, c_sd, c_sd, c_sd}, 4'b1111);
        load_and_time("v0", 16'd0, 16'h0000, 1'b0);
        check_display("v0", 4'b0011, {c_sb, c_sb, c_s0, c_s0}, 4'b1101);

        // 5: loads at +0, +3, +5; the middle one is overwritten while pending
        t_a = -1; t_b = -1; saw_c = 0;
        for (int e = 0; e < 60; e++) begin
            load  = (e == 0 || e == 3 || e == 5);
            value = (e == 0) ? 16'd500 : (e == 3) ? 16'd600 : 16'd700;
            @(negedge clk);
            load = 1'b0;
            if (t_a < 0 && dut.r_disp_bcd == 16'h0500) t_a = e;
            if (t_b < 0 && dut.r_disp_bcd == 16'h0700) t_b = e;
            if (dut.r_disp_bcd == 16'h0600) saw_c = 1;
        end
        chk("pend_first_lat", t_a, 18);
        chk("pend_last_lat", t_b, 36);
        chk("pend_overwritten", saw_c, 0);

        // Load landing on the commit edge is queued and started next edge
        t_a = -1; t_b = -1;
        for (int e = 0; e < 60; e++) begin
            load  = (e == 0 || e == 17);
            value = (e == 0) ? 16'd1111 : 16'd2222;
            @(negedge clk);
            load = 1'b0;
            if (t_a < 0 && dut.r_disp_bcd == 16'h1111) t_a = e;
            if (t_b < 0 && dut.r_disp_bcd == 16'h2222) t_b = e;
        end
        chk("done_edge_first_lat", t_a, 18);
        chk("done_edge_second_lat", t_b, 36);

        // 6: reset in the middle of a 9999 conversion
        @(negedge clk);
        value = 16'd9999;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_busy_before", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_anodes", anodes, 4'b1111);
        chk("mid_rst_segments", segments, 7'h7F);
        chk("mid_rst_dp", dp, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_disp", dut.r_disp_bcd, 16'h0000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_display("post_rst", 4'b0011, {c_sb, c_sb, c_s0, c_s0}, 4'b1101);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_disp", dut.r_disp_bcd, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
